// File: rtl/img_pkg.sv
// Shared raster constants and capture state type for the frame writer and reader.
package img_pkg;

  localparam int H_ACT     = 640;
  localparam int V_ACT     = 480;
  localparam int H_TOT     = 800;
  localparam int V_TOT     = 521;
  localparam int FRAME_PIX = H_ACT * V_ACT;
  localparam int PIX_W     = 8;
  localparam int ADDR_W    = 19;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

endpackage

// File: rtl/img_frame_ram.sv
// Simple dual-port frame store: one write port, one read-first synchronous read port.
module img_frame_ram #(
  parameter int DEPTH  = 307200,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  (* ram_style = "block" *) logic [PIX_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read register so the tools can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < ADDR_W'(DEPTH)))
      mem[wr_addr[AW-1:0]] <= wr_data;
    if (rd_addr < ADDR_W'(DEPTH))
      rd_data <= mem[rd_addr[AW-1:0]];
  end

endmodule

// File: rtl/img_write.sv
// Raster frame capture: arms on request, aligns to vsync and stores one frame in raster order.
module img_write
  import img_pkg::*;
#(
  parameter int H_ACT      = img_pkg::H_ACT,
  parameter int V_ACT      = img_pkg::V_ACT,
  parameter int PIX_W      = img_pkg::PIX_W,
  parameter int ADDR_W     = img_pkg::ADDR_W,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              de,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              capture_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int N_PIX = H_ACT * V_ACT;
  localparam int XW    = $clog2(H_ACT + 1);
  localparam int YW    = $clog2(V_ACT + 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [XW-1:0]     pix_x;
  logic [YW-1:0]     line_cnt;
  logic              hsync_d, vsync_d, de_d;
  logic              vsync_fall, de_fall, wr_en, last_pix;
  logic              unused_hsync_d;

  assign vsync_fall = vsync_d & ~vsync;
  assign de_fall    = de_d & ~de;
  // A vsync edge restarts the frame, so a coincident de pixel is not stored.
  assign wr_en      = (state == CAPTURE) && de && !vsync_fall;
  assign last_pix   = (wr_addr == ADDR_W'(N_PIX - 1));

  // Line framing relies on de; the delayed hsync is kept for timing parity with the reader.
  assign unused_hsync_d = hsync_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      pix_x      <= '0;
      line_cnt   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      hsync_d    <= 1'b1;
      vsync_d    <= 1'b1;
      de_d       <= 1'b0;
    end else begin
      hsync_d    <= hsync;
      vsync_d    <= vsync;
      de_d       <= de;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (capture_start) begin
            state     <= ARMED;
            busy      <= 1'b1;
            frame_err <= 1'b0;
          end
        end

        ARMED: begin
          if (vsync_fall) begin
            state    <= CAPTURE;
            wr_addr  <= '0;
            pix_x    <= '0;
            line_cnt <= '0;
          end
        end

        CAPTURE: begin
          if (vsync_fall) begin
            frame_err <= 1'b1;
            wr_addr   <= '0;
            pix_x     <= '0;
            line_cnt  <= '0;
          end else if (de) begin
            wr_addr <= wr_addr + 1'b1;
            pix_x   <= pix_x + 1'b1;
            if (last_pix) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
              if (CONTINUOUS) begin
                state <= ARMED;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else if (de_fall) begin
            if (pix_x != XW'(H_ACT))
              frame_err <= 1'b1;
            pix_x    <= '0;
            line_cnt <= line_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  img_frame_ram #(
    .DEPTH  (N_PIX),
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (pix_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_img_write.sv
// Bench for img_write on an 8x4 frame: single-shot and continuous instances share one pixel stream.
module tb_img_write;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int NP = HA * VA;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    pix_in = '0;
  logic          de = 1'b0;
  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic          cs0 = 1'b0;
  logic          cs1 = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [7:0] rd_data0, rd_data1, frame_cnt0, frame_cnt1;
  logic       busy0, busy1, frame_done0, frame_done1, frame_err0, frame_err1;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_q[$];
  logic [7:0] exp_mem0 [NP];
  logic [7:0] exp_mem1 [NP];

  int done0 = 0;
  int done1 = 0;
  int done_at0 = -1;
  bit watch1 = 1'b0;
  bit busy1_dropped = 1'b0;

  always #5 clk = ~clk;

  img_write #(.H_ACT(HA), .V_ACT(VA), .PIX_W(8), .ADDR_W(AW), .CONTINUOUS(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .de(de), .hsync(hsync), .vsync(vsync),
    .capture_start(cs0), .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0),
    .frame_done(frame_done0), .frame_err(frame_err0), .frame_cnt(frame_cnt0)
  );

  img_write #(.H_ACT(HA), .V_ACT(VA), .PIX_W(8), .ADDR_W(AW), .CONTINUOUS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .de(de), .hsync(hsync), .vsync(vsync),
    .capture_start(cs1), .rd_addr(rd_addr), .rd_data(rd_data1), .busy(busy1),
    .frame_done(frame_done1), .frame_err(frame_err1), .frame_cnt(frame_cnt1)
  );

  // Pulse bookkeeping on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (frame_done0) begin
      done0++;
      done_at0 = frame_q.size();
    end
    if (frame_done1) done1++;
    if (watch1 && !busy1) busy1_dropped = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    de = 1'b0;
    repeat (n) tick();
  endtask

  task automatic hblank();
    de = 1'b0;
    hsync = 1'b0;
    repeat (2) tick();
    hsync = 1'b1;
    repeat (2) tick();
  endtask

  // One frame of stimulus; pixels driven are recorded in frame_q in raster order.
  task automatic drive_frame(input bit pattern, input int short_line, input int abort_at,
                             input int cs_line, input int cs_sel);
    frame_q.delete();
    vsync = 1'b0;
    blank(2);
    vsync = 1'b1;
    blank(3);
    for (int y = 0; y < VA; y++) begin
      int n;
      n = (y == short_line) ? HA - 1 : HA;
      for (int x = 0; x < n; x++) begin
        logic [7:0] p;
        if (abort_at >= 0 && frame_q.size() == abort_at) begin
          de = 1'b0;
          return;
        end
        p = pattern ? 8'(y * HA + x) : 8'($urandom);
        if (y == cs_line && x == 0) begin
          if (cs_sel == 0) cs0 = 1'b1;
          else cs1 = 1'b1;
        end
        pix_in = p;
        de = 1'b1;
        frame_q.push_back(p);
        tick();
        cs0 = 1'b0;
        cs1 = 1'b0;
      end
      hblank();
    end
    blank(2);
  endtask

  task automatic readback(input int sel);
    for (int a = 0; a < NP; a++) begin
      rd_addr = AW'(a);
      tick();
      if (sel == 0) check($sformatf("ram0[%0d]", a), 32'(rd_data0), 32'(exp_mem0[a]));
      else          check($sformatf("ram1[%0d]", a), 32'(rd_data1), 32'(exp_mem1[a]));
    end
  endtask

  task automatic pulse_cs(input int sel);
    if (sel == 0) cs0 = 1'b1;
    else cs1 = 1'b1;
    tick();
    cs0 = 1'b0;
    cs1 = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held low.
    tick();
    tick();
    check("rst_busy0", 32'(busy0), 0);
    check("rst_done0", 32'(frame_done0), 0);
    check("rst_err0",  32'(frame_err0), 0);
    check("rst_cnt0",  32'(frame_cnt0), 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_cnt1",  32'(frame_cnt1), 0);
    rst = 1'b1;
    tick();

    // Single-shot capture of a y*8+x pattern frame.
    pulse_cs(0);
    check("t1_busy_next", 32'(busy0), 1);
    drive_frame(1'b1, -1, -1, -1, 0);
    for (int i = 0; i < NP; i++) exp_mem0[i] = frame_q[i];
    check("t1_done_cnt", 32'(done0), 1);
    check("t1_done_at",  32'(done_at0), NP);
    check("t1_frame_cnt", 32'(frame_cnt0), 1);
    check("t1_err", 32'(frame_err0), 0);
    check("t1_busy_end", 32'(busy0), 0);
    readback(0);

    // Request arrives mid-frame: that frame is skipped, the next one is captured.
    drive_frame(1'b0, -1, -1, 2, 0);
    check("t2_armed_busy", 32'(busy0), 1);
    check("t2_no_done", 32'(done0), 1);
    check("t2_cnt_hold", 32'(frame_cnt0), 1);
    drive_frame(1'b0, -1, -1, -1, 0);
    for (int i = 0; i < NP; i++) exp_mem0[i] = frame_q[i];
    check("t2_done_cnt", 32'(done0), 2);
    check("t2_done_at", 32'(done_at0), NP);
    check("t2_frame_cnt", 32'(frame_cnt0), 2);
    check("t2_err", 32'(frame_err0), 0);
    readback(0);

    // Short line sets the sticky error; next capture_start clears it.
    pulse_cs(0);
    drive_frame(1'b0, 1, -1, -1, 0);
    check("t3_err_set", 32'(frame_err0), 1);
    check("t3_no_done", 32'(done0), 2);
    check("t3_busy", 32'(busy0), 1);
    drive_frame(1'b0, -1, -1, -1, 0);
    for (int i = 0; i < NP; i++) exp_mem0[i] = frame_q[i];
    check("t3_done_cnt", 32'(done0), 3);
    check("t3_frame_cnt", 32'(frame_cnt0), 3);
    check("t3_err_sticky", 32'(frame_err0), 1);
    readback(0);
    pulse_cs(0);
    check("t3_err_clear", 32'(frame_err0), 0);

    // Early vsync after 20 pixels restarts the frame at address 0.
    drive_frame(1'b0, -1, 20, -1, 0);
    check("t4_err_before", 32'(frame_err0), 0);
    drive_frame(1'b0, -1, -1, -1, 0);
    for (int i = 0; i < NP; i++) exp_mem0[i] = frame_q[i];
    check("t4_err_set", 32'(frame_err0), 1);
    check("t4_done_cnt", 32'(done0), 4);
    check("t4_done_at", 32'(done_at0), NP);
    check("t4_frame_cnt", 32'(frame_cnt0), 4);
    readback(0);

    // Continuous instance: three back-to-back frames without re-arming.
    pulse_cs(1);
    check("t5_busy_start", 32'(busy1), 1);
    watch1 = 1'b1;
    for (int f = 0; f < 3; f++) drive_frame(1'b0, -1, -1, -1, 0);
    watch1 = 1'b0;
    for (int i = 0; i < NP; i++) exp_mem1[i] = frame_q[i];
    check("t5_done_cnt", 32'(done1), 3);
    check("t5_frame_cnt", 32'(frame_cnt1), 3);
    check("t5_busy_held", 32'(busy1_dropped), 0);
    check("t5_busy_end", 32'(busy1), 1);
    check("t5_single_idle", 32'(busy0), 0);
    readback(1);

    // Asynchronous reset in the middle of a capture, after 10 pixels.
    pulse_cs(0);
    drive_frame(1'b0, -1, 10, -1, 0);
    for (int i = 0; i < 10; i++) exp_mem0[i] = frame_q[i];
    check("t6_busy_pre", 32'(busy0), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_busy0", 32'(busy0), 0);
    check("t6_done0", 32'(frame_done0), 0);
    check("t6_cnt0", 32'(frame_cnt0), 0);
    check("t6_busy1", 32'(busy1), 0);
    check("t6_cnt1", 32'(frame_cnt1), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t6_idle", 32'(busy0), 0);
    check("t6_done_none", 32'(done0), 4);
    readback(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_write.md
Name: img_write

Overview:
- Raster frame capture block: the write-side counterpart of the frame reader/neighbourhood generator.
- Takes an 8-bit pixel stream with VGA-style hsync/vsync/de timing (640x480 active, 800x521 total) and stores one full frame into an internal block RAM in raster order.
- Typically the stream is Sobel output; the RAM exposes a synchronous read port for later readout or re-processing.
- Supports single-shot and continuous capture, and flags malformed frames.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- PIX_W, 8, pixel width
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT
- CONTINUOUS, 0, 1 = re-arm automatically after every completed frame

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- pix_in  in  PIX_W  incoming pixel, sampled when de=1
- de  in  1  data enable, high during active pixels
- hsync  in  1  horizontal sync, active-low pulse
- vsync  in  1  vertical sync, active-low pulse
- capture_start  in  1  one-cycle request to capture the next full frame
- rd_addr  in  ADDR_W  read address, raster index y*H_ACT+x
- rd_data  out  PIX_W  RAM data for rd_addr, 1-cycle latency
- busy  out  1  high in ARMED or CAPTURE
- frame_done  out  1  one-cycle pulse when the last pixel is written
- frame_err  out  1  sticky malformed-frame flag
- frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (rst=0, async) values: state=IDLE; wr_addr=0; pix_x=0; line_cnt=0; busy=0; frame_done=0; frame_err=0; frame_cnt=0; hsync_d=1; vsync_d=1. RAM contents are not cleared.
- Edge detect: registered hsync_d and vsync_d. vsync_fall = vsync_d & ~vsync; de_fall = de_d & ~de.
- IDLE:
  - capture_start=1 -> ARMED; frame_err cleared in the same cycle.
  - de and syncs ignored.
- ARMED:
  - Wait for vsync_fall -> CAPTURE with wr_addr=0, pix_x=0, line_cnt=0.
  - de pulses before the edge are ignored, so a frame is never captured mid-way.
- CAPTURE:
  - Each cycle with de=1: RAM[wr_addr] <= pix_in; wr_addr++; pix_x++. Zero-latency write on that edge.
  - de_fall: if pix_x != H_ACT, set frame_err. Then pix_x=0, line_cnt++.
  - Write of index H_ACT*V_ACT-1: frame_done=1 for the next cycle; frame_cnt++; state -> IDLE, or -> ARMED if CONTINUOUS=1.
  - vsync_fall before the full count: set frame_err, then restart at wr_addr=0 and stay in CAPTURE.
  - de=1 after line_cnt reaches V_ACT: impossible by construction, since the count completes first.
- capture_start outside IDLE is ignored.
- capture_start and frame completion in the same cycle: frame completes and state goes to IDLE (or ARMED); the start is dropped.
- Read port:
  - rd_data <= RAM[rd_addr] every cycle, independent of state.
  - On a same-cycle read/write of one address, the read returns old data (read-first).
  - rd_addr >= H_ACT*V_ACT returns undefined data.
- Widths:
  - pix_x is clog2(H_ACT+1) bits.
  - line_cnt is clog2(V_ACT+1) bits.
  - wr_addr does not wrap inside a frame; it is reset at frame start.
- Reset asserted mid-capture: immediate return to IDLE. Partially written RAM keeps its data; no frame_done pulse.

Decomposition:
- Shared package img_pkg holds:
  - H_ACT/V_ACT/H_TOT=800/V_TOT=521
  - FRAME_PIX
  - the state enum {IDLE, ARMED, CAPTURE}
  - these constants also serve the reader.
- One sub-module, img_frame_ram:
  - simple dual-port, 1 write/1 read, read-first
  - (* ram_style = "block" *), H_ACT*V_ACT x PIX_W
  - FSM, counters and edge detect stay in img_write.

Test Plan:
- Small frame H_ACT=8, V_ACT=4, CONTINUOUS=0. Pulse capture_start, drive vsync low, then 4 lines of 8 de cycles with pix_in=y*8+x -> busy=1 from the next cycle; frame_done pulses once after pixel 31; frame_cnt=1. Reading addresses 0..31 returns 0..31 one cycle later; frame_err=0.
- Start mid-frame: capture_start during line 2 of a running stream -> nothing written until the next vsync_fall. The next full frame is captured at RAM[0] = first pixel after that vsync.
- Short line: one line has 7 de cycles -> frame_err=1 at that line's de_fall and stays 1. The next capture_start clears it.
- Early vsync after 20 pixels -> frame_err=1, wr_addr restarts at 0. The following full 32-pixel frame completes with frame_done and frame_cnt=1.
- CONTINUOUS=1, three back-to-back frames -> three frame_done pulses, frame_cnt=3, busy stays 1. RAM holds the third frame.
- Async reset: rst=0 mid-capture at pixel 10 -> busy/frame_done/frame_cnt go 0 immediately without a clock. After release, pixels written before reset are still readable; state=IDLE.
- Full size 640x480 with the standard 800x521 timing -> exactly one frame_done per captured frame. RAM[640*480-1] = last active pixel.
